cpu_dmem_sequencer: RTL and testbench



---
 rtl/cpu_dmem_pkg.sv | 51 +++++
 rtl/cpu_dmem_rr_arb.sv | 29 ++
 rtl/cpu_dmem_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_cpu_dmem_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dmem_pkg.sv
// Shared types and lane-steering helpers for the mox125 data-memory sequencer.
package cpu_dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_LONG = 2'b10;  // 2'b11 also behaves as LONG

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Request fields captured at grant time.
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xfer_t;

  function automatic logic is_long(input logic [1:0] size);
    return size[1];
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic a0);
    return (size != SZ_BYTE) && a0;
  endfunction

  // Lane select of the first beat; bit 1 is the even (high) byte.
  function automatic logic [1:0] beat0_sel(input logic [1:0] size, input logic a0);
    if (size == SZ_BYTE) return a0 ? 2'b01 : 2'b10;
    return 2'b11;
  endfunction

  // Write data of the first beat: big-endian, so LONG sends its high half first.
  function automatic logic [15:0] beat0_data(input logic [1:0] size, input logic [31:0] wdata);
    if (size == SZ_BYTE) return {wdata[7:0], wdata[7:0]};
    if (is_long(size))   return wdata[31:16];
    return wdata[15:0];
  endfunction

  // Zero-extended result of a single-beat read.
  function automatic logic [31:0] read_short(input logic [1:0] size, input logic a0,
                                             input logic [15:0] dat);
    if (size == SZ_BYTE) return {24'd0, (a0 ? dat[7:0] : dat[15:8])};
    return {16'd0, dat};
  endfunction

endpackage

// File: rtl/cpu_dmem_rr_arb.sv
// Two-input round-robin arbiter; the last-grant pointer only moves when enabled.
module cpu_dmem_rr_arb (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  logic r_last;

  // Pick the requester that was not served last when both are asking.
  always_comb begin
    // NOTE: every combinational output gets a value before any branch, so no latch can be inferred.
    gnt_idx_o   = 1'b0;
    gnt_valid_o = en_i & (|req_i);
    if (req_i == 2'b11) gnt_idx_o = ~r_last;
    else                gnt_idx_o = req_i[1];
  end

  // Remember the winner; reset points at port 1 so port 0 wins the first tie.
  always_ff @(posedge clk_i) begin
    // NOTE: clocked state uses non-blocking assignment so every flop samples pre-edge values.
    if (rst_i)            r_last <= 1'b1;
    else if (gnt_valid_o) r_last <= gnt_idx_o;
  end

endmodule

// File: rtl/cpu_dmem_sequencer.sv
// Shares one 16-bit Wishbone master between store (port 0) and load (port 1)
// requesters; splits LONG accesses into two big-endian halfword beats.
module cpu_dmem_sequencer
  import cpu_dmem_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int TMO_W   = 7
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  req_i,
  input  logic [1:0]  we_i,
  input  logic [1:0]  size0_i,
  input  logic [1:0]  size1_i,
  input  logic [31:0] addr0_i,
  input  logic [31:0] addr1_i,
  input  logic [31:0] wdata0_i,
  input  logic [31:0] wdata1_i,
  output logic [31:0] rdata_o,
  output logic [1:0]  done_o,
  output logic [1:0]  err_o,
  output logic        busy_o,
  output logic [31:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  output logic [1:0]  wb_sel_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  input  logic        wb_ack_i
);

  state_e           r_state, w_state_nxt;
  xfer_t            r_xfer, w_xfer_nxt, w_req_x;
  logic             r_gnt_idx, w_gnt_idx_nxt;
  logic [TMO_W-1:0] r_tmo, w_tmo_nxt;
  logic [15:0]      r_rhi, w_rhi_nxt;
  logic [31:0]      r_rdata, w_rdata;
  logic [1:0]       r_done, w_done, r_err, w_err, r_sel, w_sel, w_gnt_onehot;
  logic [31:0]      r_adr, w_adr;
  logic [15:0]      r_dat, w_dat;
  logic             r_cyc, w_cyc, r_stb, w_stb, r_we, w_we, r_busy, w_busy;
  logic             w_arb_en, w_gnt_valid, w_gnt_idx, w_tmo_hit;

  // The cycle carrying an error pulse is treated like DONE: no new grant,
  // so the failed requester has a cycle to drop its request.
  assign w_arb_en = (r_state == ST_IDLE) && (r_err == 2'b00);

  cpu_dmem_rr_arb u_arb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (w_arb_en),
    .req_i       (req_i),
    .gnt_valid_o (w_gnt_valid),
    .gnt_idx_o   (w_gnt_idx)
  );

  assign w_tmo_hit    = (r_tmo == TMO_W'(TIMEOUT - 1));
  assign w_gnt_onehot = r_gnt_idx ? 2'b10 : 2'b01;

  // Next-state and next-output logic; everything leaves through registers.
  always_comb begin
    w_state_nxt   = r_state;
    w_xfer_nxt    = r_xfer;
    w_gnt_idx_nxt = r_gnt_idx;
    w_tmo_nxt     = r_tmo;
    w_rhi_nxt     = r_rhi;
    w_rdata       = r_rdata;
    w_done        = 2'b00;
    w_err         = 2'b00;
    w_adr         = r_adr;
    w_dat         = r_dat;
    w_sel         = r_sel;
    w_cyc         = r_cyc;
    w_stb         = r_stb;
    w_we          = r_we;

    w_req_x.we    = w_gnt_idx ? we_i[1]  : we_i[0];
    w_req_x.size  = w_gnt_idx ? size1_i  : size0_i;
    w_req_x.addr  = w_gnt_idx ? addr1_i  : addr0_i;
    w_req_x.wdata = w_gnt_idx ? wdata1_i : wdata0_i;

    case (r_state)
      ST_IDLE: begin
        if (w_gnt_valid) begin
          w_xfer_nxt    = w_req_x;
          w_gnt_idx_nxt = w_gnt_idx;
          if (is_misaligned(w_req_x.size, w_req_x.addr[0])) begin
            w_err = w_gnt_idx ? 2'b10 : 2'b01;
          end else begin
            w_state_nxt = ST_BEAT0;
            w_cyc       = 1'b1;
            w_stb       = 1'b1;
            w_we        = w_req_x.we;
            w_adr       = {w_req_x.addr[31:1], 1'b0};
            w_sel       = beat0_sel(w_req_x.size, w_req_x.addr[0]);
            w_dat       = beat0_data(w_req_x.size, w_req_x.wdata);
            w_tmo_nxt   = '0;
          end
        end
      end

      ST_BEAT0, ST_BEAT1: begin
        if (wb_ack_i) begin
          if ((r_state == ST_BEAT0) && is_long(r_xfer.size)) begin
            w_state_nxt = ST_BEAT1;
            w_adr       = r_adr + 32'd2;
            w_dat       = r_xfer.wdata[15:0];
            w_rhi_nxt   = wb_dat_i;
            w_tmo_nxt   = '0;
          end else begin
            w_state_nxt = ST_DONE;
            w_done      = w_gnt_onehot;
            w_cyc       = 1'b0;
            w_stb       = 1'b0;
            w_we        = 1'b0;
            w_sel       = 2'b00;
            if (!r_xfer.we) begin
              w_rdata = (r_state == ST_BEAT1) ? {r_rhi, wb_dat_i}
                      : read_short(r_xfer.size, r_xfer.addr[0], wb_dat_i);
            end
          end
        end else if (w_tmo_hit) begin
          // Abort; a LONG write timing out in beat 1 leaves its high half written.
          w_state_nxt = ST_IDLE;
          w_err       = w_gnt_onehot;
          w_cyc       = 1'b0;
          w_stb       = 1'b0;
          w_we        = 1'b0;
          w_sel       = 2'b00;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end

      ST_DONE: w_state_nxt = ST_IDLE;

      default: w_state_nxt = ST_IDLE;
    endcase

    w_busy = (w_state_nxt != ST_IDLE);
  end

  // State and output registers; reset clears everything, dropping any cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_xfer    <= '0;
      r_gnt_idx <= 1'b0;
      r_tmo     <= '0;
      r_rhi     <= '0;
      r_rdata   <= '0;
      r_done    <= '0;
      r_err     <= '0;
      r_busy    <= 1'b0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_sel     <= '0;
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
      r_we      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_xfer    <= w_xfer_nxt;
      r_gnt_idx <= w_gnt_idx_nxt;
      r_tmo     <= w_tmo_nxt;
      r_rhi     <= w_rhi_nxt;
      r_rdata   <= w_rdata;
      r_done    <= w_done;
      r_err     <= w_err;
      r_busy    <= w_busy;
      r_adr     <= w_adr;
      r_dat     <= w_dat;
      r_sel     <= w_sel;
      r_cyc     <= w_cyc;
      r_stb     <= w_stb;
      r_we      <= w_we;
    end
  end

  assign rdata_o  = r_rdata;
  assign done_o   = r_done;
  assign err_o    = r_err;
  assign busy_o   = r_busy;
  assign wb_adr_o = r_adr;
  assign wb_dat_o = r_dat;
  assign wb_sel_o = r_sel;
  assign wb_cyc_o = r_cyc;
  assign wb_stb_o = r_stb;
  assign wb_we_o  = r_we;

endmodule

// File: tb/tb_cpu_dmem_sequencer.sv
// Bench for cpu_dmem_sequencer: transaction-level model plus directed vectors.
module tb_cpu_dmem_sequencer;

  logic        clk;
  logic        rst_i;
  logic [1:0]  req_i, we_i, size0_i, size1_i;
  logic [31:0] addr0_i, addr1_i, wdata0_i, wdata1_i;
  logic [31:0] rdata_o, wb_adr_o;
  logic [1:0]  done_o, err_o, wb_sel_o;
  logic        busy_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
  logic [15:0] wb_dat_o, wb_dat_i;

  cpu_dmem_sequencer #(.TIMEOUT(64), .TMO_W(7)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
    .size0_i(size0_i), .size1_i(size1_i), .addr0_i(addr0_i), .addr1_i(addr1_i),
    .wdata0_i(wdata0_i), .wdata1_i(wdata1_i), .rdata_o(rdata_o), .done_o(done_o),
    .err_o(err_o), .busy_o(busy_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o), .wb_ack_i(wb_ack_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct {
    logic [31:0] adr;
    logic [15:0] dat;
    logic [1:0]  sel;
    logic        we;
  } beat_t;

  typedef struct {
    int          port;
    bit          is_err;
    logic [31:0] rdata;
  } cpl_t;

  beat_t       exp_beats[$];
  beat_t       obs_beats[$];
  cpl_t        exp_cpls[$];
  logic        m_last;
  logic [31:0] m_rdata;
  logic [15:0] smem[logic [31:0]];
  int          ack_wait;

  logic        d_we[2];
  logic [1:0]  d_size[2];
  logic [31:0] d_addr[2];
  logic [31:0] d_wdata[2];

  function automatic logic [15:0] slave_word(input logic [31:0] a);
    if (smem.exists(a)) return smem[a];
    return a[15:0] ^ 16'hC3C3;
  endfunction

  // mode: 0 normal, 1 slave never acks, 2 reset lands in beat 1 (no completion)
  task automatic push_model(input int p, input int mode);
    logic [31:0] a0;
    logic [15:0] hw;
    beat_t       b;
    cpl_t        c;
    a0       = {d_addr[p][31:1], 1'b0};
    c.port   = p;
    c.is_err = 1'b0;
    c.rdata  = m_rdata;
    if ((d_size[p] != 2'b00 && d_addr[p][0]) || mode == 1) begin
      c.is_err = 1'b1;
      exp_cpls.push_back(c);
      return;
    end
    b.adr = a0;
    b.we  = d_we[p];
    if (d_size[p] == 2'b00) begin
      b.sel = d_addr[p][0] ? 2'b01 : 2'b10;
      b.dat = {2{d_wdata[p][7:0]}};
      hw    = slave_word(a0);
      if (!d_we[p]) m_rdata = {24'd0, (d_addr[p][0] ? hw[7:0] : hw[15:8])};
      exp_beats.push_back(b);
    end else if (d_size[p] == 2'b01) begin
      b.sel = 2'b11;
      b.dat = d_wdata[p][15:0];
      if (!d_we[p]) m_rdata = {16'd0, slave_word(a0)};
      exp_beats.push_back(b);
    end else begin
      b.sel = 2'b11;
      b.dat = d_wdata[p][31:16];
      exp_beats.push_back(b);
      if (mode == 2) return;
      b.adr = a0 + 32'd2;
      b.dat = d_wdata[p][15:0];
      exp_beats.push_back(b);
      if (!d_we[p]) m_rdata = {slave_word(a0), slave_word(a0 + 32'd2)};
    end
    c.rdata = m_rdata;
    exp_cpls.push_back(c);
  endtask

  // ---------------- Wishbone slave: acks after ack_wait stall cycles ----------------
  int s_cnt;
  initial begin
    wb_ack_i = 1'b0;
    wb_dat_i = '0;
    s_cnt    = 0;
    forever begin
      @(negedge clk);
      if (wb_cyc_o === 1'b1 && wb_stb_o === 1'b1) begin
        wb_dat_i = slave_word(wb_adr_o);
        if (ack_wait >= 0 && s_cnt >= ack_wait) begin
          wb_ack_i = 1'b1;
          s_cnt    = 0;
        end else begin
          wb_ack_i = 1'b0;
          s_cnt++;
        end
      end else begin
        wb_ack_i = 1'b0;
        s_cnt    = 0;
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin
    beat_t b;
    cpl_t  c;
    forever begin
      @(negedge clk);
      #2;
      if (rst_i === 1'b0) begin
        check("cyc_eq_stb", wb_stb_o, wb_cyc_o);
        if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
          b.adr = wb_adr_o; b.dat = wb_dat_o; b.sel = wb_sel_o; b.we = wb_we_o;
          obs_beats.push_back(b);
          if (exp_beats.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_beat: got adr 0x%0h expected no beat", wb_adr_o);
          end else begin
            b = exp_beats.pop_front();
            check("beat_adr", wb_adr_o, b.adr);
            check("beat_sel", wb_sel_o, b.sel);
            check("beat_we", wb_we_o, b.we);
            if (b.we) check("beat_dat", wb_dat_o, b.dat);
          end
        end
        if (done_o != 2'b00 || err_o != 2'b00) begin
          if (exp_cpls.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_cpl: got done %b err %b expected none", done_o, err_o);
          end else begin
            c = exp_cpls.pop_front();
            check("cpl_done", done_o, c.is_err ? 2'b00 : (c.port == 1 ? 2'b10 : 2'b01));
            check("cpl_err", err_o, c.is_err ? (c.port == 1 ? 2'b10 : 2'b01) : 2'b00);
            if (!c.is_err) check("cpl_rdata", rdata_o, c.rdata);
          end
        end
      end
    end
  end

  // ---------------- requester driver ----------------
  int          lat[2];
  logic [31:0] rd_done[2];
  logic        got_err[2];
  logic [31:0] busy_hist;
  logic        saw_cyc;
  int          stb_cnt;

  task automatic set_port(input int p, input logic we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata);
    d_we[p] = we; d_size[p] = size; d_addr[p] = addr; d_wdata[p] = wdata;
    we_i[p] = we;
    if (p == 0) begin size0_i = size; addr0_i = addr; wdata0_i = wdata; end
    else        begin size1_i = size; addr1_i = addr; wdata1_i = wdata; end
  endtask

  // Request on the ports in mask at cycle 0 and record the cycle of each completion.
  task automatic run(input logic [1:0] mask, input int mode);
    int         first;
    logic [1:0] pend;
    if (mask == 2'b11) begin
      first = m_last ? 0 : 1;
      push_model(first, mode);
      push_model(1 - first, mode);
      m_last = (first == 0);
    end else begin
      first = mask[1] ? 1 : 0;
      push_model(first, mode);
      m_last = mask[1];
    end
    lat = '{-1, -1};
    rd_done = '{32'd0, 32'd0};
    got_err = '{1'b0, 1'b0};
    busy_hist = '0; saw_cyc = 1'b0; stb_cnt = 0;
    obs_beats.delete();
    @(posedge clk);
    #1 req_i = mask;
    pend = mask;
    for (int k = 0; k < 300 && pend != 2'b00; k++) begin
      @(negedge clk);
      #3;
      if (k < 32) busy_hist[k] = busy_o;
      if (wb_cyc_o) saw_cyc = 1'b1;
      if (wb_stb_o) stb_cnt++;
      for (int p = 0; p < 2; p++) begin
        if (pend[p] && (done_o[p] || err_o[p])) begin
          lat[p]     = k;
          rd_done[p] = rdata_o;
          got_err[p] = err_o[p];
          pend[p]    = 1'b0;
          req_i[p]   = 1'b0;
        end
      end
    end
    check("run_complete", pend, 2'b00);
    req_i = 2'b00;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_ctl"}, {done_o, err_o, busy_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}, 0);
    check({pfx, "_adr"}, wb_adr_o, 0);
    check({pfx, "_dat"}, wb_dat_o, 0);
    check({pfx, "_rdata"}, rdata_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_i = 1'b1; req_i = '0; we_i = '0; size0_i = '0; size1_i = '0;
    addr0_i = '0; addr1_i = '0; wdata0_i = '0; wdata1_i = '0;
    ack_wait = 0; m_last = 1'b1; m_rdata = '0;
    smem[32'h2002] = 16'h12AB;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk); #3;
    check_all_zero("reset");

    // LONG write, zero-wait slave
    set_port(0, 1'b1, 2'b10, 32'h1000, 32'hDEADBEEF);
    run(2'b01, 0);
    check("long_wr_lat", lat[0], 3);
    check("long_wr_busy", busy_hist[3:0], 4'b1110);
    check("long_wr_nbeats", obs_beats.size(), 2);
    if (obs_beats.size() == 2) begin
      check("long_wr_beat0", {obs_beats[0].adr, obs_beats[0].dat, obs_beats[0].sel},
            {32'h1000, 16'hDEAD, 2'b11});
      check("long_wr_beat1", {obs_beats[1].adr, obs_beats[1].dat, obs_beats[1].sel},
            {32'h1002, 16'hBEEF, 2'b11});
    end

    // BYTE reads from both lanes
    set_port(1, 1'b0, 2'b00, 32'h2003, 32'h0);
    run(2'b10, 0);
    check("byte_odd_rdata", rd_done[1], 32'h000000AB);
    check("byte_odd_lat", lat[1], 2);
    if (obs_beats.size() > 0) check("byte_odd_sel", obs_beats[0].sel, 2'b01);
    set_port(1, 1'b0, 2'b00, 32'h2002, 32'h0);
    run(2'b10, 0);
    check("byte_even_rdata", rd_done[1], 32'h00000012);
    if (obs_beats.size() > 0) check("byte_even_sel", obs_beats[0].sel, 2'b10);

    // Tie after port 1 was served: port 0 first
    set_port(0, 1'b1, 2'b01, 32'h0100, 32'h00001234);
    set_port(1, 1'b0, 2'b10, 32'h0200, 32'h0);
    run(2'b11, 0);
    check("tie1_lat0", lat[0], 2);
    check("tie1_lat1", lat[1], 6);
    check("tie1_rdata", rd_done[1], 32'hC1C3C1C1);
    // Repeated tie: port 1 was last again, so port 0 first again
    set_port(0, 1'b1, 2'b00, 32'h0105, 32'h00000077);
    set_port(1, 1'b0, 2'b01, 32'h0204, 32'h0);
    run(2'b11, 0);
    check("tie2_lat0", lat[0], 2);
    check("tie2_lat1", lat[1], 5);
    check("tie2_rdata", rd_done[1], 32'h0000C1C7);
    // Port 0 alone, then a tie: order flips to port 1 first
    set_port(0, 1'b0, 2'b01, 32'h0300, 32'h0);
    run(2'b01, 0);
    set_port(0, 1'b1, 2'b10, 32'h0400, 32'h01234567);
    set_port(1, 1'b0, 2'b00, 32'h0207, 32'h0);
    run(2'b11, 0);
    check("tie3_lat1", lat[1], 2);
    check("tie3_lat0", lat[0], 6);
    check("tie3_rdata", rd_done[1], 32'h000000C5);

    // Misaligned HALF write: error, no bus cycle
    set_port(0, 1'b1, 2'b01, 32'h3001, 32'h5555);
    run(2'b01, 0);
    check("misal_lat", lat[0], 1);
    check("misal_err", got_err[0], 1'b1);
    check("misal_nocyc", saw_cyc, 1'b0);
    set_port(0, 1'b0, 2'b01, 32'h3002, 32'h0);
    set_port(1, 1'b1, 2'b00, 32'h3003, 32'h000000A5);
    run(2'b11, 0);
    check("after_misal_lat1", lat[1], 2);
    check("after_misal_lat0", lat[0], 5);
    set_port(1, 1'b0, 2'b11, 32'h5005, 32'h0);
    run(2'b10, 0);
    check("misal_long_lat", lat[1], 1);
    check("misal_long_nocyc", saw_cyc, 1'b0);

    // Slave never acks: 64 strobe cycles then error
    ack_wait = -1;
    set_port(0, 1'b0, 2'b01, 32'h4000, 32'h0);
    run(2'b01, 1);
    check("tmo_lat", lat[0], 65);
    check("tmo_stb_cycles", stb_cnt, 64);
    check("tmo_err", got_err[0], 1'b1);
    // Ack in the last allowed cycle wins
    ack_wait = 63;
    set_port(1, 1'b0, 2'b01, 32'h4002, 32'h0);
    run(2'b10, 0);
    check("late_ack_lat", lat[1], 65);
    check("late_ack_stb_cycles", stb_cnt, 64);
    check("late_ack_noerr", got_err[1], 1'b0);

    // Reset during beat 1 of a LONG read
    ack_wait = 3;
    set_port(1, 1'b0, 2'b10, 32'h6000, 32'h0);
    push_model(1, 2);
    @(posedge clk);
    #1 req_i = 2'b10;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk); #3;
    end
    check("rst_pre_beat1", {wb_adr_o, wb_stb_o}, {32'h6002, 1'b1});
    rst_i = 1'b1; req_i = 2'b00; m_last = 1'b1; m_rdata = '0;
    @(negedge clk); #3;
    check_all_zero("rst_mid");
    rst_i = 1'b0;
    ack_wait = 0;
    // Fresh tie after reset: port 0 wins again
    set_port(0, 1'b0, 2'b01, 32'h7000, 32'h0);
    set_port(1, 1'b1, 2'b00, 32'h7001, 32'h0000003C);
    run(2'b11, 0);
    check("post_rst_lat0", lat[0], 2);
    check("post_rst_lat1", lat[1], 5);
    check("post_rst_rdata", rd_done[0], 32'h0000B3C3);

    repeat (3) @(posedge clk);
    check("beats_left", exp_beats.size(), 0);
    check("cpls_left", exp_cpls.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
